// File: rtl/tea_pkg.sv
// Shared definitions for the tea_interface host-side sequencer: sequencer
// states, cipher direction encoding, bus widths and default wait windows.
package tea_pkg;

  localparam int KEY_W = 128;
  localparam int BLK_W = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Default wait window after the write strobe: ready is ignored below
  // READY_MIN_DEF waited cycles, the block is abandoned at TIMEOUT_DEF.
  localparam int READY_MIN_DEF = 32;
  localparam int TIMEOUT_DEF   = 64;

  typedef enum logic [2:0] {
    IDLE,
    KEY_HI,
    KEY_LO,
    WRITE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/tea_host_driver.sv
// Initiator-side sequencer for tea_interface. Takes keys and blocks over
// valid/ready, replays the core's two-cycle key load and one-cycle write,
// waits for a trustworthy out_ready and hands the result back on a
// valid/ready response channel. Only one block is ever outstanding.
// TIMEOUT must be larger than READY_MIN, otherwise every block times out.
module tea_host_driver
  import tea_pkg::*;
#(
  parameter int READY_MIN = READY_MIN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [BLK_W-1:0] req_data,
  input  logic             req_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BLK_W-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             key_loaded,
  output logic [BLK_W-1:0] core_in,
  output logic             core_mode,
  output logic             core_reset,
  output logic             core_write,
  input  logic [BLK_W-1:0] core_out,
  input  logic             core_out_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(READY_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e           r_state;
  logic [BLK_W-1:0] r_core_in;
  logic             r_core_mode;
  logic             r_core_reset;
  logic             r_core_write;
  logic [BLK_W-1:0] r_key_lo;
  logic             r_key_loaded;
  logic             r_key_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [BLK_W-1:0] r_rsp_data;
  logic             r_rsp_timeout;

  state_e           w_state_next;
  logic [BLK_W-1:0] w_core_in_next;
  logic             w_core_mode_next;
  logic             w_core_reset_next;
  logic             w_core_write_next;
  logic [BLK_W-1:0] w_key_lo_next;
  logic             w_key_loaded_next;
  logic             w_key_ready_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_rsp_valid_next;
  logic [BLK_W-1:0] w_rsp_data_next;
  logic             w_rsp_timeout_next;
  logic             w_req_ready;

  // A pending key always wins over a block offered in the same cycle, and
  // no block is taken until the core holds a key.
  assign w_req_ready = r_key_ready && r_key_loaded && !key_valid;

  assign key_ready   = r_key_ready;
  assign req_ready   = w_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  assign key_loaded  = r_key_loaded;
  assign core_in     = r_core_in;
  assign core_mode   = r_core_mode;
  assign core_reset  = r_core_reset;
  assign core_write  = r_core_write;

  // Next-state and next registered-output values for the sequencer.
  always_comb begin
    w_state_next       = r_state;
    w_core_in_next     = r_core_in;
    w_core_mode_next   = r_core_mode;
    w_core_reset_next  = 1'b0;
    w_core_write_next  = 1'b0;
    w_key_lo_next      = r_key_lo;
    w_key_loaded_next  = r_key_loaded;
    w_cnt_next         = r_cnt;
    w_rsp_data_next    = r_rsp_data;
    w_rsp_timeout_next = r_rsp_timeout;

    case (r_state)
      IDLE: begin
        if (key_valid && r_key_ready) begin
          w_state_next      = KEY_HI;
          w_core_reset_next = 1'b1;
          w_core_in_next    = key[KEY_W-1:BLK_W];
          w_key_lo_next     = key[BLK_W-1:0];
        end else if (req_valid && w_req_ready) begin
          w_state_next      = WRITE;
          w_core_write_next = 1'b1;
          w_core_in_next    = req_data;
          w_core_mode_next  = req_mode;
        end
      end
      KEY_HI: begin
        w_state_next   = KEY_LO;
        w_core_in_next = r_key_lo;
      end
      KEY_LO: begin
        w_state_next      = IDLE;
        w_key_loaded_next = 1'b1;
      end
      WRITE: begin
        w_state_next = WAIT;
        w_cnt_next   = CNT_W'(1);
      end
      WAIT: begin
        if (core_out_ready && (r_cnt >= CNT_MIN)) begin
          w_state_next       = RESP;
          w_rsp_data_next    = core_out;
          w_rsp_timeout_next = 1'b0;
        end else if (r_cnt >= CNT_MAX) begin
          w_state_next       = RESP;
          w_rsp_data_next    = '0;
          w_rsp_timeout_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_key_ready_next = (w_state_next == IDLE);
    w_rsp_valid_next = (w_state_next == RESP);
  end

  // State and every registered output; reset drops any block in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_core_in     <= '0;
      r_core_mode   <= 1'b0;
      r_core_reset  <= 1'b0;
      r_core_write  <= 1'b0;
      r_key_lo      <= '0;
      r_key_loaded  <= 1'b0;
      r_key_ready   <= 1'b0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_core_in     <= w_core_in_next;
      r_core_mode   <= w_core_mode_next;
      r_core_reset  <= w_core_reset_next;
      r_core_write  <= w_core_write_next;
      r_key_lo      <= w_key_lo_next;
      r_key_loaded  <= w_key_loaded_next;
      r_key_ready   <= w_key_ready_next;
      r_cnt         <= w_cnt_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_data    <= w_rsp_data_next;
      r_rsp_timeout <= w_rsp_timeout_next;
    end
  end

endmodule

// File: tb/tb_tea_host_driver.sv
// Bench for tea_host_driver: a behavioural stub of tea_interface with
// programmable out_ready behaviour, plus a cycle-level reference model of
// the expected response latency, data and timeout flag.
module tb_tea_host_driver;
  import tea_pkg::*;

  localparam logic [127:0] KNOWN_KEY = 128'h2b02056806144976775d0e266c287843;
  localparam logic [63:0]  KNOWN_PT  = 64'h74657374206d652e;
  localparam logic [63:0]  KNOWN_CT  = 64'h775d2a6af6ce9209;

  logic clk = 1'b0;
  logic reset_n;
  logic key_valid, key_ready;
  logic [127:0] key;
  logic req_valid, req_ready, req_mode;
  logic [63:0] req_data;
  logic rsp_valid, rsp_ready, rsp_timeout, key_loaded;
  logic [63:0] rsp_data, core_in;
  logic core_mode, core_reset, core_write;
  logic [63:0] core_out = 64'd0;
  logic core_out_ready = 1'b0;
  logic [135:0] allOut;

  int vectors = 0;
  int errors  = 0;

  // Stub core state: 0 = ready after stubDelay cycles, 1 = ready stuck high,
  // 2 = ready stuck low.
  int stubMode  = 0;
  int stubDelay = 10;
  int stubCnt   = 0;
  logic stubBusy = 1'b0;
  logic stubLoPending = 1'b0;
  logic [63:0] stubKeyHi = 64'd0, stubKeyLo = 64'd0, stubIn = 64'd0;
  logic stubMd = 1'b0;
  logic [63:0] modelKeyHi = 64'd0, modelKeyLo = 64'd0;

  always #5 clk = ~clk;

  assign allOut = {key_ready, req_ready, rsp_valid, rsp_data, rsp_timeout,
                   key_loaded, core_in, core_mode, core_reset, core_write};

  tea_host_driver dut (
    .clk(clk), .reset_n(reset_n),
    .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_mode(req_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .key_loaded(key_loaded),
    .core_in(core_in), .core_mode(core_mode), .core_reset(core_reset), .core_write(core_write),
    .core_out(core_out), .core_out_ready(core_out_ready)
  );

  // Stand-in for the cipher: reproduces the known TEA vectors and scrambles
  // anything else with the key so a wrong key or block shows up in rsp_data.
  function automatic logic [63:0] coreFunc(input logic [63:0] blk, input logic md,
                                           input logic [63:0] hi, input logic [63:0] lo);
    if ({hi, lo} == KNOWN_KEY && md == MODE_ENC && blk == KNOWN_PT) return KNOWN_CT;
    if ({hi, lo} == KNOWN_KEY && md == MODE_DEC && blk == KNOWN_CT) return KNOWN_PT;
    return {blk[40:0], blk[63:41]} ^ hi ^ {lo[31:0], lo[63:32]} ^
           (md ? 64'hA5A55A5A0F0FF0F0 : 64'h0123456789ABCDEF);
  endfunction

  // Behavioural tea_interface: captures the key halves and the written
  // block, then raises out_ready according to stubMode/stubDelay.
  always @(posedge clk) begin
    if (core_reset) begin
      stubKeyHi     <= core_in;
      stubLoPending <= 1'b1;
    end else if (stubLoPending) begin
      stubKeyLo     <= core_in;
      stubLoPending <= 1'b0;
    end
    if (core_write) begin
      stubIn         <= core_in;
      stubMd         <= core_mode;
      stubCnt        <= 0;
      stubBusy       <= (stubMode == 0);
      core_out_ready <= (stubMode == 1);
      if (stubMode == 1) core_out <= coreFunc(core_in, core_mode, stubKeyHi, stubKeyLo);
    end else if (stubBusy) begin
      if (stubCnt + 1 == stubDelay) begin
        core_out_ready <= 1'b1;
        core_out       <= coreFunc(stubIn, stubMd, stubKeyHi, stubKeyLo);
        stubBusy       <= 1'b0;
      end
      stubCnt <= stubCnt + 1;
    end
  end

  task automatic loadKey(input logic [127:0] k);
    bit hs = 0;
    @(negedge clk);
    key_valid = 1'b1;
    key = k;
    for (int i = 0; i < 20 && !hs; i++) begin
      #1;
      if (key_ready) hs = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!hs) begin
      errors++;
      $display("[TB] FAIL key_handshake: key_ready never seen, need 1");
      key_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    vectors++;
    if ({core_reset, core_in, key_ready} !== {1'b1, k[127:64], 1'b0}) begin
      errors++;
      $display("[TB] FAIL key_hi_cycle: reset=%b in=%h kr=%b, need 1 %h 0", core_reset, core_in, key_ready, k[127:64]);
    end
    @(posedge clk); #1;
    vectors++;
    if ({core_reset, core_in} !== {1'b0, k[63:0]}) begin
      errors++;
      $display("[TB] FAIL key_lo_cycle: reset=%b in=%h, need 0 %h", core_reset, core_in, k[63:0]);
    end
    @(posedge clk); #1;
    vectors++;
    if ({key_loaded, key_ready, core_reset} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL key_done: loaded=%b kr=%b reset=%b, need 1 1 0", key_loaded, key_ready, core_reset);
    end
    vectors++;
    if ({stubKeyHi, stubKeyLo} !== k) begin
      errors++;
      $display("[TB] FAIL key_at_core: %h, need %h", {stubKeyHi, stubKeyLo}, k);
    end
    modelKeyHi = k[127:64];
    modelKeyLo = k[63:0];
  endtask

  // One block end to end. Reference model: the response leaves after
  // exitW waited cycles, where waiting starts one cycle after the write
  // strobe; ready counts once READY_MIN cycles have been waited, and at
  // TIMEOUT waited cycles the block is abandoned.
  task automatic runBlock(input logic [63:0] data, input logic md, input int sMode,
                          input int delay, input int hold, input string tag);
    int readyW, exitW, expLat, lat, writes;
    logic expTo;
    logic [63:0] expData;
    bit hs = 0, holdOk = 1, busyOk = 1;
    stubMode  = sMode;
    stubDelay = delay;
    if (sMode == 1) readyW = 1;
    else if (sMode == 2) readyW = 100000;
    else readyW = delay + 1;
    if (readyW <= TIMEOUT_DEF) begin
      expTo = 1'b0;
      exitW = (readyW > READY_MIN_DEF) ? readyW : READY_MIN_DEF;
    end else begin
      expTo = 1'b1;
      exitW = TIMEOUT_DEF;
    end
    expLat  = exitW + 1;
    expData = expTo ? 64'd0 : coreFunc(data, md, modelKeyHi, modelKeyLo);

    @(negedge clk);
    req_valid = 1'b1;
    req_data  = data;
    req_mode  = md;
    for (int i = 0; i < 20 && !hs; i++) begin
      #1;
      if (req_ready) hs = 1;
      else @(negedge clk);
    end
    vectors++;
    if (!hs) begin
      errors++;
      $display("[TB] FAIL %s req_handshake: req_ready never seen, need 1", tag);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = {$urandom, $urandom};
    req_mode  = ~md;
    vectors++;
    if ({core_write, core_in, core_mode} !== {1'b1, data, md}) begin
      errors++;
      $display("[TB] FAIL %s write_cycle: w=%b in=%h m=%b, need 1 %h %b", tag, core_write, core_in, core_mode, data, md);
    end
    writes = 1;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (core_write) writes++;
      if (rsp_valid) break;
      if (core_in !== data || core_mode !== md || key_ready !== 1'b0 || req_ready !== 1'b0) busyOk = 0;
    end
    vectors++;
    if (busyOk !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s wait_hold: core_in/mode not held or ready seen while busy, got %b need 1", tag, busyOk);
    end
    vectors++;
    if (lat !== expLat) begin
      errors++;
      $display("[TB] FAIL %s latency: %0d cycles, need %0d", tag, lat, expLat);
    end
    vectors++;
    if (writes !== 1) begin
      errors++;
      $display("[TB] FAIL %s write_pulses: %0d, need 1", tag, writes);
    end
    vectors++;
    if ({rsp_valid, rsp_timeout, rsp_data} !== {1'b1, expTo, expData}) begin
      errors++;
      $display("[TB] FAIL %s response: v=%b to=%b d=%h, need 1 %b %h", tag, rsp_valid, rsp_timeout, rsp_data, expTo, expData);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_valid = 1'b1;
      @(posedge clk); #1;
      if ({rsp_valid, rsp_timeout, rsp_data} !== {1'b1, expTo, expData} ||
          req_ready !== 1'b0 || key_ready !== 1'b0 || core_write !== 1'b0) holdOk = 0;
    end
    vectors++;
    if (holdOk !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s resp_hold: response changed or request taken while held, got %b need 1", tag, holdOk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if ({rsp_valid, key_ready, core_write} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL %s resp_done: v=%b kr=%b w=%b, need 0 1 0", tag, rsp_valid, key_ready, core_write);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    key_valid = 1'b0; key = '0;
    req_valid = 1'b0; req_data = '0; req_mode = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (allOut !== 136'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: %h, need 0", allOut);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({key_ready, req_ready, key_loaded} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL after_reset: kr=%b rr=%b kl=%b, need 1 0 0", key_ready, req_ready, key_loaded);
    end
  endtask

  task automatic test_no_req_before_key();
    bit ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = {$urandom, $urandom};
      #1;
      if (req_ready !== 1'b0) ok = 0;
      @(posedge clk); #1;
      if (core_write !== 1'b0) ok = 0;
    end
    req_valid = 1'b0;
    vectors++;
    if (ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_before_key: block accepted without key, got %b need 1", ok);
    end
  endtask

  task automatic test_key_priority();
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key_valid = 1'b1; key = k;
    req_valid = 1'b1; req_data = {$urandom, $urandom};
    #1;
    vectors++;
    if ({req_ready, key_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL key_priority: rr=%b kr=%b, need 0 1", req_ready, key_ready);
    end
    @(posedge clk); #1;
    key_valid = 1'b0; req_valid = 1'b0;
    vectors++;
    if ({core_reset, core_write, core_in} !== {1'b1, 1'b0, k[127:64]}) begin
      errors++;
      $display("[TB] FAIL priority_key_taken: rst=%b w=%b in=%h, need 1 0 %h", core_reset, core_write, core_in, k[127:64]);
    end
    repeat (2) @(posedge clk);
    #1;
    modelKeyHi = k[127:64];
    modelKeyLo = k[63:0];
    vectors++;
    if ({key_loaded, stubKeyHi, stubKeyLo} !== {1'b1, k}) begin
      errors++;
      $display("[TB] FAIL reload_key: kl=%b key=%h, need 1 %h", key_loaded, {stubKeyHi, stubKeyLo}, k);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 3) == 0) loadKey({$urandom, $urandom, $urandom, $urandom});
      sel = $urandom_range(0, 4);
      runBlock({$urandom, $urandom}, 1'($urandom_range(0, 1)),
               (sel <= 2) ? 0 : sel - 2, $urandom_range(1, 70), $urandom_range(0, 4), "random");
    end
  endtask

  task automatic test_reset_mid_wait();
    bit quiet = 1;
    stubMode = 2;
    @(negedge clk);
    req_valid = 1'b1;
    req_data  = {$urandom, $urandom};
    req_mode  = MODE_ENC;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midwait_accept: req_ready=%b, need 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (allOut !== 136'd0) begin
      errors++;
      $display("[TB] FAIL midwait_reset_outputs: %h, need 0", allOut);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || core_write !== 1'b0 || core_reset !== 1'b0 || key_loaded !== 1'b0) quiet = 0;
    end
    vectors++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midwait_no_response: activity after reset, got %b need 1", quiet);
    end
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midwait_key_cleared: req_ready=%b, need 0", req_ready);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_req_before_key();
    loadKey(KNOWN_KEY);
    runBlock(KNOWN_PT, MODE_ENC, 0, 32, 0, "known_enc");
    runBlock(KNOWN_CT, MODE_DEC, 0, 32, 0, "known_dec");
    runBlock({$urandom, $urandom}, MODE_ENC, 0, 20, 10, "resp_hold");
    runBlock({$urandom, $urandom}, MODE_DEC, 1, 1, 0, "stuck_ready");
    runBlock({$urandom, $urandom}, MODE_ENC, 2, 1, 2, "stuck_low");
    runBlock({$urandom, $urandom}, MODE_ENC, 0, 30, 0, "ready_early");
    runBlock({$urandom, $urandom}, MODE_DEC, 0, 31, 0, "ready_at_min");
    runBlock({$urandom, $urandom}, MODE_ENC, 0, 63, 0, "ready_at_timeout");
    runBlock({$urandom, $urandom}, MODE_DEC, 0, 64, 1, "ready_too_late");
    test_key_priority();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Backstop so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, need finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
